// File: rtl/axis_video_pattern_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern source.
// Pixel layout is BGRA: B[31:24] G[23:16] R[15:8] A[7:0].
package axis_video_pattern_pkg;

  localparam int PIX_W = 32;

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    BARS    = 2'd1,
    RAMP    = 2'd2,
    CHECKER = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  localparam logic [PIX_W-1:0] WHITE = 32'hFFFF_FFFF;
  localparam logic [PIX_W-1:0] BLACK = 32'h0000_00FF;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [PIX_W-1:0] BAR_COLOR [8] = '{
    32'hFFFF_FFFF, 32'h00FF_FFFF, 32'hFFFF_00FF, 32'h00FF_00FF,
    32'hFF00_FFFF, 32'h0000_FFFF, 32'hFF00_00FF, 32'h0000_00FF
  };

endpackage

// File: rtl/axis_video_pattern_pixel.sv
// Combinational pattern generator: one BGRA pixel from (mode, x, y[3], solid colour).
module axis_video_pattern_pixel
  import axis_video_pattern_pkg::*;
#(
  parameter int IMAGE_WIDTH = 640
) (
  input  logic [1:0]       i_mode,
  input  logic [15:0]      i_x,
  input  logic             i_y_b3,
  input  logic [PIX_W-1:0] i_solid,
  output logic [PIX_W-1:0] o_pixel
);

  logic [2:0] w_bar;

  assign w_bar = 3'(({16'd0, i_x} * 32'd8) / 32'(IMAGE_WIDTH));

  always_comb begin
    o_pixel = BLACK;
    case (pattern_e'(i_mode))
      SOLID:   o_pixel = i_solid;
      BARS:    o_pixel = BAR_COLOR[w_bar];
      RAMP:    o_pixel = {i_x[7:0], i_x[7:0], i_x[7:0], 8'hFF};
      CHECKER: o_pixel = (i_x[3] ^ i_y_b3) ? WHITE : BLACK;
      default: o_pixel = BLACK;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_src.sv
// AXI4-Stream (UG934 framing) BGRA test-pattern source: tuser = SOF, tlast = EOL.
// Define AXIS_VPG_BLANKING_EN to insert HBLANK/VBLANK idle cycles between lines/frames.
module axis_video_pattern_src
  import axis_video_pattern_pkg::*;
#(
  parameter int IMAGE_WIDTH    = 640,
  parameter int IMAGE_HEIGHT   = 426,
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32,
  parameter int HBLANK         = 16,
  parameter int VBLANK         = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          continuous,
  input  logic                          stop,
  input  logic [1:0]                    mode,
  input  logic [31:0]                   solid_color,
  output logic [PIXEL_PER_CLK*32-1:0]   m_axis_video_tdata,
  output logic                          m_axis_video_tvalid,
  input  logic                          m_axis_video_tready,
  output logic                          m_axis_video_tlast,
  output logic                          m_axis_video_tuser,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic [1:0]                    dbg_state
);

  localparam int BEAT_W = PIXEL_PER_CLK * PIX_W;
  localparam logic [15:0] X_LAST = 16'(IMAGE_WIDTH - PIXEL_PER_CLK);
  localparam logic [15:0] Y_LAST = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] X_STEP = 16'(PIXEL_PER_CLK);
  localparam logic [15:0] H_LOAD = 16'(HBLANK - 1);
  localparam logic [15:0] V_LOAD = 16'(VBLANK - 1);

`ifdef AXIS_VPG_BLANKING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam bit H_BLANK_ON = BLANK_EN && (HBLANK > 0);
  localparam bit V_BLANK_ON = BLANK_EN && (VBLANK > 0);

  if ((IMAGE_WIDTH % PIXEL_PER_CLK) != 0) begin : g_bad_width
    $error("IMAGE_WIDTH must be a multiple of PIXEL_PER_CLK");
  end
  if ((PIXEL_PER_CLK != 1 && PIXEL_PER_CLK != 2 && PIXEL_PER_CLK != 4 && PIXEL_PER_CLK != 8)
      || BITS_PER_PIXEL != 32) begin : g_bad_format
    $error("PIXEL_PER_CLK must be 1/2/4/8 and BITS_PER_PIXEL must be 32");
  end
  if (HBLANK < 0 || HBLANK > 65536 || VBLANK < 0 || VBLANK > 65536) begin : g_bad_blank
    $error("HBLANK/VBLANK must fit the 16-bit blanking counter");
  end

  state_e             r_state;
  logic [15:0]        r_x, r_y, r_blank, r_frame_count;
  logic [1:0]         r_mode;
  logic [31:0]        r_solid;
  logic [BEAT_W-1:0]  r_tdata;
  logic               r_tvalid, r_tlast, r_tuser, r_frame_done, r_stop;

  logic               w_accept, w_eol, w_eof, w_continue, w_load, w_sof;
  logic [15:0]        w_gx, w_gy;
  logic [1:0]         w_mode;
  logic [31:0]        w_solid;
  logic [BEAT_W-1:0]  w_pix;

  assign w_accept   = r_tvalid & m_axis_video_tready;
  assign w_eol      = (r_x == X_LAST);
  assign w_eof      = w_eol & (r_y == Y_LAST);
  // A stop arriving with the final beat still ends this frame.
  assign w_continue = continuous & ~(r_stop | stop);

  // Coordinate of the beat to load into the output register this cycle.
  always_comb begin
    w_load = 1'b0;
    w_sof  = 1'b0;
    w_gx   = r_x;
    w_gy   = r_y;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_sof  = 1'b1;
          w_gx   = 16'd0;
          w_gy   = 16'd0;
        end
      end
      ST_ACTIVE: begin
        if (w_accept) begin
          if (!w_eol) begin
            w_load = 1'b1;
            w_gx   = r_x + X_STEP;
          end else if (!w_eof) begin
            w_load = !H_BLANK_ON;
            w_gx   = 16'd0;
            w_gy   = r_y + 16'd1;
          end else begin
            w_load = w_continue & !V_BLANK_ON;
            w_sof  = 1'b1;
            w_gx   = 16'd0;
            w_gy   = 16'd0;
          end
        end
      end
      ST_HBLANK: w_load = (r_blank == 16'd0);
      ST_VBLANK: begin
        w_load = (r_blank == 16'd0);
        w_sof  = 1'b1;
      end
    endcase
  end

  // Mode and solid colour come straight from the inputs on the SOF beat, then hold.
  assign w_mode  = w_sof ? mode : r_mode;
  assign w_solid = w_sof ? solid_color : r_solid;

  for (genvar i = 0; i < PIXEL_PER_CLK; i++) begin : g_pix
    axis_video_pattern_pixel #(.IMAGE_WIDTH(IMAGE_WIDTH)) u_pix (
      .i_mode  (w_mode),
      .i_x     (w_gx + 16'(i)),
      .i_y_b3  (w_gy[3]),
      .i_solid (w_solid),
      .o_pixel (w_pix[i*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_blank       <= 16'd0;
      r_frame_count <= 16'd0;
      r_mode        <= 2'd0;
      r_solid       <= 32'd0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_stop        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_pix;
        r_tlast  <= (w_gx == X_LAST);
        r_tuser  <= w_sof;
        r_x      <= w_gx;
        r_y      <= w_gy;
      end
      if (w_load && w_sof) begin
        r_mode  <= mode;
        r_solid <= solid_color;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ACTIVE;
            r_stop  <= stop;
          end
        end
        ST_ACTIVE: begin
          if (stop) r_stop <= 1'b1;
          if (w_accept && w_eol) begin
            if (!w_eof) begin
              if (H_BLANK_ON) begin
                r_tvalid <= 1'b0;
                r_x      <= 16'd0;
                r_y      <= r_y + 16'd1;
                r_blank  <= H_LOAD;
                r_state  <= ST_HBLANK;
              end
            end else begin
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 16'd1;
              if (w_continue) begin
                if (V_BLANK_ON) begin
                  r_tvalid <= 1'b0;
                  r_x      <= 16'd0;
                  r_y      <= 16'd0;
                  r_blank  <= V_LOAD;
                  r_state  <= ST_VBLANK;
                end
              end else begin
                r_tvalid <= 1'b0;
                r_stop   <= 1'b0;
                r_state  <= ST_IDLE;
              end
            end
          end
        end
        ST_HBLANK, ST_VBLANK: begin
          if (stop) r_stop <= 1'b1;
          if (r_blank == 16'd0) r_state <= ST_ACTIVE;
          else                  r_blank <= r_blank - 16'd1;
        end
      endcase
    end
  end

  assign m_axis_video_tdata  = r_tdata;
  assign m_axis_video_tvalid = r_tvalid;
  assign m_axis_video_tlast  = r_tlast;
  assign m_axis_video_tuser  = r_tuser;
  assign busy                = (r_state != ST_IDLE);
  assign frame_done          = r_frame_done;
  assign frame_count         = r_frame_count;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_axis_video_pattern_src.sv
// Bench for axis_video_pattern_src: DUT A is 8x4 PPC=1, DUT B is 16x2 PPC=4.
`timescale 1ns/1ps
module tb_axis_video_pattern_src;

  localparam int AW = 8;
  localparam int AH = 4;
  localparam int BW = 16;
`ifdef AXIS_VPG_BLANKING_EN
  localparam int H_EXP = 3;
  localparam int V_EXP = 5;
`else
  localparam int H_EXP = 0;
  localparam int V_EXP = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;

  // DUT A
  logic        a_start = 0, a_cont = 0, a_stop = 0;
  logic [1:0]  a_mode = 0;
  logic [31:0] a_solid = 0;
  logic        a_tready = 1'b1;
  logic        rand_rdy = 1'b0;
  logic [31:0] a_tdata;
  logic        a_tvalid, a_tlast, a_tuser, a_busy, a_fd;
  logic [15:0] a_fc;
  logic [1:0]  a_state;

  axis_video_pattern_src #(
    .IMAGE_WIDTH(AW), .IMAGE_HEIGHT(AH), .PIXEL_PER_CLK(1),
    .BITS_PER_PIXEL(32), .HBLANK(3), .VBLANK(5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .continuous(a_cont), .stop(a_stop),
    .mode(a_mode), .solid_color(a_solid),
    .m_axis_video_tdata(a_tdata), .m_axis_video_tvalid(a_tvalid),
    .m_axis_video_tready(a_tready), .m_axis_video_tlast(a_tlast),
    .m_axis_video_tuser(a_tuser), .busy(a_busy), .frame_done(a_fd),
    .frame_count(a_fc), .dbg_state(a_state)
  );

  // DUT B
  logic         b_start = 0;
  logic [1:0]   b_mode = 0;
  logic [127:0] b_tdata;
  logic         b_tvalid, b_tlast, b_tuser, b_busy, b_fd;
  logic [15:0]  b_fc;
  logic [1:0]   b_state;

  axis_video_pattern_src #(
    .IMAGE_WIDTH(BW), .IMAGE_HEIGHT(2), .PIXEL_PER_CLK(4),
    .BITS_PER_PIXEL(32), .HBLANK(3), .VBLANK(5)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .continuous(1'b0), .stop(1'b0),
    .mode(b_mode), .solid_color(32'd0),
    .m_axis_video_tdata(b_tdata), .m_axis_video_tvalid(b_tvalid),
    .m_axis_video_tready(1'b1), .m_axis_video_tlast(b_tlast),
    .m_axis_video_tuser(b_tuser), .busy(b_busy), .frame_done(b_fd),
    .frame_count(b_fc), .dbg_state(b_state)
  );

  always @(posedge clk) begin
    #1;
    a_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [31:0] ref_pix(int m, int x, int y, logic [31:0] solid, int w);
    case (m)
      0: return solid;
      1: case ((x * 8) / w)
           0: return 32'hFFFFFFFF;
           1: return 32'h00FFFFFF;
           2: return 32'hFFFF00FF;
           3: return 32'h00FF00FF;
           4: return 32'hFF00FFFF;
           5: return 32'h0000FFFF;
           6: return 32'hFF0000FF;
           default: return 32'h000000FF;
         endcase
      2: return {x[7:0], x[7:0], x[7:0], 8'hFF};
      default: return (x[3] ^ y[3]) ? 32'hFFFFFFFF : 32'h000000FF;
    endcase
  endfunction

  // scoreboard A: {eof, tuser, tlast, tdata}
  logic [34:0] a_q[$];
  logic [34:0] a_e;
  logic [33:0] a_hold_pay;
  logic        a_fd_exp = 0, a_hold = 0, a_prev_eol = 0, a_prev_eof = 0;
  int          a_beats = 0, a_frames_exp = 0, a_idle = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete();
      a_fd_exp = 0; a_frames_exp = 0; a_hold = 0;
      a_prev_eol = 0; a_prev_eof = 0; a_idle = 0;
    end else begin
      if (a_fd_exp || a_fd) begin
        chk("a_frame_done", a_fd, a_fd_exp);
        if (a_fd_exp) begin
          a_frames_exp++;
          chk("a_frame_count", a_fc, 16'(a_frames_exp));
        end
      end
      a_fd_exp = 0;
      if (a_hold) chk("a_hold_stable", {a_tvalid, a_tuser, a_tlast, a_tdata}, {1'b1, a_hold_pay});
      if (!a_busy) begin
        a_prev_eol = 0; a_prev_eof = 0; a_idle = 0;
      end else if (!a_tvalid) begin
        a_idle++;
      end
      if (a_tvalid && a_tready) begin
        a_beats++;
        if (a_prev_eof && a_tuser) chk("a_vblank_gap", a_idle, V_EXP);
        else if (a_prev_eol)       chk("a_hblank_gap", a_idle, H_EXP);
        if (a_q.size() == 0) begin
          tests++; errors++;
          $display("FAIL a_unexpected_beat: got %0h expected none", {a_tuser, a_tlast, a_tdata});
          a_prev_eof = 0;
        end else begin
          a_e = a_q.pop_front();
          chk("a_beat", {a_tuser, a_tlast, a_tdata}, a_e[33:0]);
          a_fd_exp = a_e[34];
          a_prev_eof = a_e[34];
        end
        a_prev_eol = a_tlast;
        a_idle = 0;
      end
      a_hold = a_tvalid && !a_tready;
      a_hold_pay = {a_tuser, a_tlast, a_tdata};
    end
  end

  // scoreboard B: {eof, tuser, tlast, tdata[127:0]}
  logic [130:0] b_q[$];
  logic [130:0] b_e;
  logic         b_fd_exp = 0;
  int           b_frames_exp = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_q.delete();
      b_fd_exp = 0; b_frames_exp = 0;
    end else begin
      if (b_fd_exp || b_fd) begin
        chk("b_frame_done", b_fd, b_fd_exp);
        if (b_fd_exp) begin
          b_frames_exp++;
          chk("b_frame_count", b_fc, 16'(b_frames_exp));
        end
      end
      b_fd_exp = 0;
      if (b_tvalid) begin
        if (b_q.size() == 0) begin
          tests++; errors++;
          $display("FAIL b_unexpected_beat: got %0h expected none", {b_tuser, b_tlast, b_tdata});
        end else begin
          b_e = b_q.pop_front();
          chk("b_beat", {b_tuser, b_tlast, b_tdata}, b_e[129:0]);
          b_fd_exp = b_e[130];
        end
      end
    end
  end

  // driver tasks
  task automatic push_a_frame(int m, logic [31:0] solid);
    for (int y = 0; y < AH; y++) begin
      for (int x = 0; x < AW; x++) begin
        logic [31:0] d;
        d = ref_pix(m, x, y, solid, AW);
        if (m == 2 && x == 0 && y == 0) d = 32'h000000FF;
        a_q.push_back({1'(x == AW-1 && y == AH-1), 1'(x == 0 && y == 0), 1'(x == AW-1), d});
      end
    end
  endtask

  task automatic push_b_frame(int m);
    for (int k = 0; k < 8; k++) begin
      logic [127:0] d;
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = ref_pix(m, (k % 4) * 4 + i, k / 4, 32'd0, BW);
      if (m == 1 && k == 0) d = {32'h00FFFFFF, 32'h00FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      b_q.push_back({1'(k == 7), 1'(k == 0), 1'(k % 4 == 3), d});
    end
  endtask

  task automatic start_a(logic [1:0] m, logic [31:0] solid, logic cont, logic stp);
    @(posedge clk); #1;
    chk("a_tvalid_before_start", a_tvalid, 0);
    a_mode = m; a_solid = solid; a_cont = cont; a_stop = stp; a_start = 1;
    @(posedge clk); #1;
    a_start = 0; a_stop = 0;
    chk("a_tvalid_rise", a_tvalid, 1);
    chk("a_busy_rise", a_busy, 1);
  endtask

  task automatic start_b(logic [1:0] m);
    @(posedge clk); #1;
    b_mode = m; b_start = 1;
    @(posedge clk); #1;
    b_start = 0;
  endtask

  task automatic wait_idle_a(string name);
    int n = 0;
    while ((a_q.size() != 0 || a_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) fail_now(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle_b(string name);
    int n = 0;
    while ((b_q.size() != 0 || b_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) fail_now(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beats_a(int target, string name);
    int n = 0;
    while (a_beats < target && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) fail_now(name);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_tvalid", a_tvalid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_frame_done", a_fd, 0);
    chk("rst_a_frame_count", a_fc, 0);
    chk("rst_a_state", a_state, 0);
    chk("rst_b_tvalid", b_tvalid, 0);
    rst_n = 1;

    // single ramp frame, tready=1
    push_a_frame(2, 32'd0);
    start_a(2, 32'd0, 0, 0);
    wait_idle_a("t1_timeout");
    chk("t1_frame_count", a_fc, 16'd1);
    chk("t1_busy", a_busy, 0);

    // same frame, random tready
    rand_rdy = 1;
    push_a_frame(2, 32'd0);
    start_a(2, 32'd0, 0, 0);
    wait_idle_a("t2_timeout");
    rand_rdy = 0;
    chk("t2_frame_count", a_fc, 16'd2);

    // continuous solid frames; colour changes mid-frame, stop in line 1 of frame 2
    push_a_frame(0, 32'h11223344);
    push_a_frame(0, 32'h55667788);
    base = a_beats;
    start_a(0, 32'h11223344, 1, 0);
    a_solid = 32'h55667788;
    wait_beats_a(base + AW * AH + AW, "t3_stop_wait");
    @(posedge clk); #1; a_stop = 1;
    @(posedge clk); #1; a_stop = 0;
    wait_idle_a("t3_timeout");
    a_cont = 0;
    chk("t3_frame_count", a_fc, 16'd4);
    repeat (20) @(negedge clk);
    chk("t3_no_restart_tvalid", a_tvalid, 0);
    chk("t3_busy", a_busy, 0);

    // start and stop together while idle in continuous mode: exactly one frame
    push_a_frame(2, 32'd0);
    start_a(2, 32'd0, 1, 1);
    wait_idle_a("t4_timeout");
    a_cont = 0;
    chk("t4_frame_count", a_fc, 16'd5);

    // PPC=4 bars, then checker
    push_b_frame(1);
    start_b(1);
    wait_idle_b("t5_timeout");
    chk("t5_frame_count", b_fc, 16'd1);
    push_b_frame(3);
    start_b(3);
    wait_idle_b("t6_timeout");
    chk("t6_frame_count", b_fc, 16'd2);

    // reset mid-line, then a clean frame
    push_a_frame(2, 32'd0);
    base = a_beats;
    start_a(2, 32'd0, 0, 0);
    wait_beats_a(base + 10, "t7_wait");
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("t7_rst_tvalid", a_tvalid, 0);
    chk("t7_rst_busy", a_busy, 0);
    chk("t7_rst_frame_count", a_fc, 0);
    chk("t7_rst_b_frame_count", b_fc, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    push_a_frame(2, 32'd0);
    start_a(2, 32'd0, 0, 0);
    wait_idle_a("t8_timeout");
    chk("t8_frame_count", a_fc, 16'd1);
    chk("t8_queue_empty", a_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
